// File: rtl/riscv_boot_sequencer_if.sv
// rtl/riscv_boot_sequencer_if.sv - program-word stream and instruction-memory write port bundle
interface riscv_boot_sequencer_if #(
   parameter int ADDR_W = 8
);
   logic              in_valid;
   logic              in_ready;
   logic [31:0]       in_data;
   logic              in_last;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;

   // host / program source side
   modport master (
      output in_valid, in_data, in_last,
      input  in_ready, imem_we, imem_addr, imem_wdata
   );

   // sequencer side
   modport slave (
      input  in_valid, in_data, in_last,
      output in_ready, imem_we, imem_addr, imem_wdata
   );
endinterface

// File: rtl/riscv_boot_sequencer.sv
// rtl/riscv_boot_sequencer.sv - loads a program into imem under core reset, then runs a bounded window
module riscv_boot_sequencer #(
   parameter int ADDR_W     = 8,
   parameter int RST_HOLD   = 2,
   parameter int RUN_CYCLES = 20,
   parameter int RUN_W      = 16
) (
   input  logic                 clk,
   input  logic                 reset,
   riscv_boot_sequencer_if.slave bus,
   input  logic                 halt_i,
   input  logic                 start,
   output logic                 core_reset,
   output logic                 running,
   output logic                 done,
   output logic                 timeout,
   output logic [ADDR_W:0]      load_count,
   output logic [RUN_W-1:0]     run_count
);

   typedef enum logic [1:0] {S_LOAD, S_HOLD, S_RUN, S_DONE} state_t;

   localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [ADDR_W:0]   LAST_SLOT = (ADDR_W+1)'((1 << ADDR_W) - 1);
   localparam logic [RUN_W-1:0]  RUN_LAST  = RUN_W'(RUN_CYCLES - 1);

   state_t              state_q, state_d;
   logic [HOLD_W-1:0]   hold_q, hold_d;
   logic                in_ready_q, in_ready_d;
   logic                we_q, we_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [31:0]         wdata_q, wdata_d;
   logic                core_reset_q, core_reset_d;
   logic                running_q, running_d;
   logic                done_q, done_d;
   logic                timeout_q, timeout_d;
   logic [ADDR_W:0]     lc_q, lc_d;
   logic [RUN_W-1:0]    rc_q, rc_d;

   logic accept, last_word, hold_done;

   // the final word is either flagged by the source or fills the last memory slot
   assign accept    = (state_q == S_LOAD) && bus.in_valid && in_ready_q;
   assign last_word = accept && (bus.in_last || (lc_q == LAST_SLOT));
   assign hold_done = (state_q == S_HOLD) && (hold_q == HOLD_LAST);

   // state and registered outputs; reset parks the core in LOAD with the core held in reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= S_LOAD;
         hold_q       <= '0;
         in_ready_q   <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         core_reset_q <= 1'b1;
         running_q    <= 1'b0;
         done_q       <= 1'b0;
         timeout_q    <= 1'b0;
         lc_q         <= '0;
         rc_q         <= '0;
      end else begin
         state_q      <= state_d;
         hold_q       <= hold_d;
         in_ready_q   <= in_ready_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         core_reset_q <= core_reset_d;
         running_q    <= running_d;
         done_q       <= done_d;
         timeout_q    <= timeout_d;
         lc_q         <= lc_d;
         rc_q         <= rc_d;
      end
   end

   // next-state: halt outranks window expiry; the hold counter restarts on entry to HOLD
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      case (state_q)
         S_LOAD: begin
            if (last_word) begin
               state_d = S_HOLD;
               hold_d  = '0;
            end
         end
         S_HOLD: begin
            if (hold_done) state_d = S_RUN;
            else           hold_d  = hold_q + 1'b1;
         end
         S_RUN: begin
            if (halt_i || (rc_q == RUN_LAST)) state_d = S_DONE;
         end
         S_DONE: begin
            if (start) state_d = S_LOAD;
         end
         default: state_d = S_LOAD;
      endcase
   end

   // next values of the registered outputs, decoded from the upcoming state
   always_comb begin
      in_ready_d   = (state_d == S_LOAD);
      core_reset_d = (state_d != S_RUN);
      running_d    = (state_d == S_RUN);
      done_d       = (state_d == S_DONE);
      we_d         = accept;
      addr_d       = accept ? lc_q[ADDR_W-1:0] : addr_q;
      wdata_d      = accept ? bus.in_data : wdata_q;
      lc_d         = accept ? lc_q + 1'b1 : lc_q;
      rc_d         = rc_q;
      timeout_d    = timeout_q;
      case (state_q)
         S_HOLD: begin
            if (hold_done) rc_d = '0;
         end
         S_RUN: begin
            rc_d = rc_q + 1'b1;
            if (state_d == S_DONE) timeout_d = ~halt_i;
         end
         S_DONE: begin
            if (start) begin
               lc_d      = '0;
               rc_d      = '0;
               timeout_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   assign bus.in_ready   = in_ready_q;
   assign bus.imem_we    = we_q;
   assign bus.imem_addr  = addr_q;
   assign bus.imem_wdata = wdata_q;
   assign core_reset     = core_reset_q;
   assign running        = running_q;
   assign done           = done_q;
   assign timeout        = timeout_q;
   assign load_count     = lc_q;
   assign run_count      = rc_q;

endmodule
